axis_sample_unpacker: RTL and testbench

- AXI4-Stream slave that takes 128-bit beats (8 lanes x 16 bits, LSB-aligned 12-bit samples) and buffers them in a small FIFO.
- Emits 96-bit beats (8 x 12-bit samples, sample 0 in bits [11:0]) on an AXI4-Stream master.
- Receive-side counterpart of the 12-to-16-bit lane packer that feeds the FIR/LPF stream IP; sits between IP output and 12-bit sample consumers (trigger, beamformer, capture).
- Flags lanes whose upper nibble is not a valid extension of the 12-bit sample.

---
 rtl/axis_sample_unpacker.sv | 157 +++++++++++++++
 tb/tb_axis_sample_unpacker.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sample_unpacker.sv
// axis_sample_unpacker
//   Receives 128-bit AXI4-Stream beats made of 8 lanes x 16 bits, each lane
//   carrying an LSB-aligned 12-bit sample. The beats are stored in a small
//   FIFO and sent out as 96-bit beats of 8 packed 12-bit samples, with
//   sample 0 in bits [11:0]. A lane whose upper nibble is not a valid
//   extension of its 12-bit sample is flagged. The flag per lane is sticky,
//   and a saturating counter totals the flagged lanes.
//
// Optional build macro: UNPACK_SATURATE_EN
//   When defined, an out-of-range lane is clamped to the nearest
//   representable 12-bit value before it is stored. When it is not defined,
//   the lane is truncated to bits [11:0].
//
// Ports
//   clk_i, rst_i        clock; asynchronous active-high reset
//   flush_i             synchronous clear of the FIFO, the flags and the counter
//   s_axis_*            128-bit slave stream (input lanes)
//   m_axis_*            96-bit master stream (packed samples)
//   ovr_lanes_o         sticky out-of-range flag for each lane
//   ovr_count_o         count of out-of-range lanes, saturates at 0xFFFF
//   level_o             FIFO occupancy in beats
module axis_sample_unpacker #(
    parameter int DEPTH  = 4,
    parameter int SIGNED = 1,
    parameter int NLANE  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [NLANE*16-1:0]      s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [NLANE*12-1:0]      m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [NLANE-1:0]         ovr_lanes_o,
    output logic [15:0]              ovr_count_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(NLANE + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [NLANE*12-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [NLANE-1:0]    ovr_q, ovr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                rdy_en_q;

    logic [NLANE-1:0]    bad_lane;
    logic [NLANE*12-1:0] conv_beat;
    logic [CW-1:0]       n_bad;
    logic [16:0]         cnt_sum;
    logic                full, push, pop;

    for (genvar j = 0; j < NLANE; j++) begin : g_lane
        logic [15:0] lane;
        assign lane = s_axis_tdata[16*j +: 16];

        if (SIGNED != 0) begin : g_signed
            assign bad_lane[j] = (lane[15:12] != {4{lane[11]}});
`ifdef UNPACK_SATURATE_EN
            // The sign of the clamp comes from lane bit 15, the true sign of the wide value.
            assign conv_beat[12*j +: 12] = !bad_lane[j] ? lane[11:0] :
                                           (lane[15] ? 12'h800 : 12'h7FF);
`else
            assign conv_beat[12*j +: 12] = lane[11:0];
`endif
        end else begin : g_unsigned
            assign bad_lane[j] = |lane[15:12];
`ifdef UNPACK_SATURATE_EN
            assign conv_beat[12*j +: 12] = bad_lane[j] ? 12'hFFF : lane[11:0];
`else
            assign conv_beat[12*j +: 12] = lane[11:0];
`endif
        end
    end

    always_comb begin
        n_bad = '0;
        for (int j = 0; j < NLANE; j++) begin
            n_bad = n_bad + CW'(bad_lane[j]);
        end
    end

    assign full          = (level_q == FULL_LVL);
    // rdy_en_q keeps tready low until the first edge after reset is released.
    assign s_axis_tready = rdy_en_q && !full && !flush_i;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = (level_q != '0);
    assign pop           = m_axis_tvalid && m_axis_tready && !flush_i;
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
    assign cnt_sum       = {1'b0, cnt_q} + 17'(n_bad);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovr_d    = ovr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovr_d    = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                ovr_d    = ovr_q | bad_lane;
                cnt_d    = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= '0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Storage has no reset. The output is gated by level, so stale entries are never visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= conv_beat;
        end
    end

    assign ovr_lanes_o = ovr_q;
    assign ovr_count_o = cnt_q;
    assign level_o     = level_q;

endmodule

// File: tb/tb_axis_sample_unpacker.sv
module tb_axis_sample_unpacker;

    localparam int DEPTH  = 4;
    localparam int SIGNED = 1;
    localparam int NLANE  = 8;

    logic         clk = 1'b0;
    logic         rst_i, flush_i;
    logic [127:0] s_tdata;
    logic         s_tvalid, s_tready;
    logic [95:0]  m_tdata;
    logic         m_tvalid, m_tready;
    logic [7:0]   ovr_lanes;
    logic [15:0]  ovr_count;
    logic [2:0]   level;

    always #5 clk = ~clk;

    axis_sample_unpacker #(.DEPTH(DEPTH), .SIGNED(SIGNED), .NLANE(NLANE)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .ovr_lanes_o(ovr_lanes), .ovr_count_o(ovr_count), .level_o(level)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Reference model: a queue of converted beats plus the flags and the counter.
    logic [95:0] mq[$];
    logic [7:0]  m_flags;
    int          m_count;
    bit          m_rdy;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] conv(input logic [127:0] d, output logic [7:0] bad);
        logic [95:0] r;
        logic [15:0] lane;
        int v;
        r = '0;
        bad = '0;
        for (int j = 0; j < 8; j++) begin
            lane = d[16*j +: 16];
            if (SIGNED != 0) begin
                v = int'($signed(lane));
                bad[j] = (v < -2048) || (v > 2047);
            end else begin
                v = int'({16'h0, lane});
                bad[j] = (v > 4095);
            end
            r[12*j +: 12] = lane[11:0];
`ifdef UNPACK_SATURATE_EN
            if (bad[j]) begin
                if (SIGNED != 0) r[12*j +: 12] = (v < 0) ? 12'h800 : 12'h7FF;
                else             r[12*j +: 12] = 12'hFFF;
            end
`endif
        end
        return r;
    endfunction

    function automatic logic [95:0] rep12(input logic [11:0] s);
        return {8{s}};
    endfunction

    function automatic logic [127:0] rep16(input logic [15:0] s);
        return {8{s}};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_flags = '0;
        m_count = 0;
        m_rdy   = 1'b0;
    endtask

    function automatic bit model_tready();
        return m_rdy && (mq.size() < DEPTH) && !flush_i;
    endfunction

    task automatic model_edge();
        logic [7:0]  b;
        logic [95:0] cb;
        bit          tr, po, pu;
        if (rst_i) begin
            model_reset();
            return;
        end
        tr = model_tready();
        if (flush_i) begin
            mq.delete();
            m_flags = '0;
            m_count = 0;
        end else begin
            po = (mq.size() != 0) && m_tready;
            pu = s_tvalid && tr;
            if (po) void'(mq.pop_front());
            if (pu) begin
                cb = conv(s_tdata, b);
                mq.push_back(cb);
                m_flags = m_flags | b;
                m_count = m_count + $countones(b);
                if (m_count > 65535) m_count = 65535;
            end
        end
        m_rdy = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_tready", 128'(s_tready), 128'(model_tready()));
            check("cmp_tvalid", 128'(m_tvalid), 128'(mq.size() != 0));
            check("cmp_tdata",  128'(m_tdata),  (mq.size() != 0) ? 128'(mq[0]) : 128'h0);
            check("cmp_level",  128'(level),    128'(mq.size()));
            check("cmp_flags",  128'(ovr_lanes), 128'(m_flags));
            check("cmp_count",  128'(ovr_count), 128'(m_count));
        end
    end

    initial begin : stim
        logic [127:0] d;
        logic [11:0]  s12;
        logic [95:0]  exp96;

        rst_i = 1'b1; flush_i = 1'b0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
        model_reset();
        #7;
        check("rst_tvalid", 128'(m_tvalid), 128'h0);
        check("rst_tdata",  128'(m_tdata),  128'h0);
        check("rst_level",  128'(level),    128'h0);
        check("rst_tready", 128'(s_tready), 128'h0);
        check("rst_flags",  128'(ovr_lanes), 128'h0);
        check("rst_count",  128'(ovr_count), 128'h0);
        #1 rst_i = 1'b0;
        cmp_en = 1'b1;
        step();
        check("rel_tready", 128'(s_tready), 128'h1);

        // Three beats of 0x3E8 with the output always ready
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = rep16(16'h03E8);
        check("pre_tvalid", 128'(m_tvalid), 128'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("dc_tvalid", 128'(m_tvalid), 128'h1);
            check("dc_tdata",  128'(m_tdata),  128'(rep12(12'h3E8)));
        end
        s_tvalid = 1'b0;
        step();
        check("dc_count", 128'(ovr_count), 128'h0);
        check("dc_level", 128'(level),     128'h0);

        // Impulse on lane 5
        s_tdata = '0;
        s_tdata[16*5 +: 16] = 16'hFC18;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        exp96 = '0;
        exp96[60 +: 12] = 12'hC18;
        check("imp_tdata", 128'(m_tdata), 128'(exp96));
        check("imp_flags", 128'(ovr_lanes), 128'h0);
        step();

        // Backpressure: five beats into a four-deep FIFO
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_tdata = rep16(16'(i + 1));
            step();
        end
        check("bp_level",  128'(level),    128'h4);
        check("bp_tready", 128'(s_tready), 128'h0);
        s_tdata = rep16(16'h0005);
        step();
        step();
        check("bp_hold_level", 128'(level),   128'h4);
        check("bp_head",       128'(m_tdata), 128'(rep12(12'h001)));
        m_tready = 1'b1;
        step();
        check("bp_pop_level", 128'(level),   128'h3);
        check("bp_next",      128'(m_tdata), 128'(rep12(12'h002)));
        step();
        s_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("bp_drained", 128'(level), 128'h0);

        // Out-of-range lanes 0 and 7
        m_tready = 1'b0;
        s_tdata = '0;
        s_tdata[15:0]    = 16'h1234;
        s_tdata[127:112] = 16'h8001;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        check("oor_flags", 128'(ovr_lanes), 128'h81);
        check("oor_count", 128'(ovr_count), 128'h2);
`ifdef UNPACK_SATURATE_EN
        check("oor_tdata", 128'(m_tdata), 128'({12'h800, 72'h0, 12'h7FF}));
`else
        check("oor_tdata", 128'(m_tdata), 128'({12'h001, 72'h0, 12'h234}));
`endif
        m_tready = 1'b1;
        step();

        // Flush at level 3 with a concurrent push
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = rep16(16'(16'h0010 + i));
            s_tdata[16*2 +: 16] = 16'h7000;
            step();
        end
        check("fl_pre_level", 128'(level), 128'h3);
        flush_i = 1'b1;
        s_tdata = rep16(16'h0077);
        step();
        check("fl_level",  128'(level),     128'h0);
        check("fl_tvalid", 128'(m_tvalid),  128'h0);
        check("fl_flags",  128'(ovr_lanes), 128'h0);
        check("fl_count",  128'(ovr_count), 128'h0);
        flush_i = 1'b0;
        s_tvalid = 1'b0;
        step();
        check("fl_after_level", 128'(level), 128'h0);

        // Asynchronous reset mid-stream at level 2
        s_tvalid = 1'b1;
        s_tdata = rep16(16'h0F00);
        step();
        s_tdata = rep16(16'h0123);
        step();
        s_tvalid = 1'b0;
        check("ar_pre_level", 128'(level), 128'h2);
        #1 rst_i = 1'b1;
        model_reset();
        #1;
        check("ar_tvalid", 128'(m_tvalid),  128'h0);
        check("ar_tdata",  128'(m_tdata),   128'h0);
        check("ar_level",  128'(level),     128'h0);
        check("ar_flags",  128'(ovr_lanes), 128'h0);
        check("ar_count",  128'(ovr_count), 128'h0);
        check("ar_tready", 128'(s_tready),  128'h0);
        step();
        #1 rst_i = 1'b0;
        step();
        check("ar_rel_tready", 128'(s_tready), 128'h1);
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata = rep16(16'h0ABC);
        check("ar_pre_tvalid", 128'(m_tvalid), 128'h0);
        step();
        s_tvalid = 1'b0;
        check("ar_lat_tvalid", 128'(m_tvalid), 128'h1);
        check("ar_lat_tdata",  128'(m_tdata),  128'(rep12(12'hABC)));
        step();

        // Randomized traffic, flushes included
        for (int c = 0; c < 3000; c++) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            m_tready = ($urandom_range(0, 2) != 0);
            flush_i  = ($urandom_range(0, 39) == 0);
            for (int j = 0; j < 8; j++) begin
                if ($urandom_range(0, 5) == 0) begin
                    d[16*j +: 16] = 16'($urandom);
                end else begin
                    s12 = 12'($urandom);
                    d[16*j +: 16] = (SIGNED != 0) ? {{4{s12[11]}}, s12} : {4'h0, s12};
                end
            end
            s_tdata = d;
            step();
        end
        flush_i = 1'b0;

        // The counter saturates: 8200 beats with every lane out of range
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata = rep16(16'h8000);
        for (int c = 0; c < 8200; c++) step();
        s_tvalid = 1'b0;
        step();
        check("sat_count", 128'(ovr_count), 128'hFFFF);
        check("sat_flags", 128'(ovr_lanes), 128'hFF);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
